// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width and baud helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // Clocks per bit for a given system clock and line rate; shared with the transmitter.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous pad inputs; flops reset to 1 (line idle).
module uart_rx_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready byte output.
// Optional parity bit between data and stop: define UART_RX_PARITY_EN.
// CLKS_PER_BIT = CLK_FREQ/BAUD must be at least 4.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic                 rxs;

`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`else
    logic                 unused_cfg;
    assign unused_cfg = ^PARITY_ODD;
    assign parity_err = 1'b0;
`endif

    uart_rx_sync #(.W(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    // Frame FSM, bit timing, deserialiser and output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            idx       <= '0;
            shift     <= '0;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!rxs) begin
                        state <= START;
                    end
                end

                // Re-check the line at mid start bit to reject glitches.
                START: begin
                    if (bit_cnt == CNT_HALF) begin
                        bit_cnt <= '0;
                        idx     <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_cnt == CNT_FULL) begin
                        bit_cnt    <= '0;
                        shift[idx] <= rxs;
                        if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_cnt == CNT_FULL) begin
                        bit_cnt <= '0;
                        par_bad <= rxs != ((^shift) ^ PARITY_ODD[0]);
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`endif

                // Mid stop bit: deliver, drop on overrun, or flag framing error.
                STOP: begin
                    if (bit_cnt == CNT_FULL) begin
                        bit_cnt <= '0;
                        if (rxs) begin
                            if (!valid || ready) begin
                                data  <= shift;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                // Hold off until the line returns high so a break gives one error.
                BREAK: begin
                    bit_cnt <= '0;
                    if (rxs) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial tx model drives rx, received bytes
// are checked against a queue of expected bytes. Honours UART_RX_PARITY_EN.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_mem [0:255];
    int got_n = 0;
    int rd = 0;
    int valid_cycles = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    // Monitor: record handshaken bytes and count pulses, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) valid_cycles = valid_cycles + 1;
            if (valid && ready) begin
                got_mem[got_n[7:0]] = data;
                got_n = got_n + 1;
            end
            if (frame_err)  fe_cnt = fe_cnt + 1;
            if (overrun)    ov_cnt = ov_cnt + 1;
            if (parity_err) pe_cnt = pe_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serial transmitter model; rx is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [7:0] b, input logic par_bit, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        tick(CPB);
`else
        if (par_bit === 1'bx) rx = 1'b1;
`endif
        rx = stop_bit;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_frame(b, ^b, stop_bit);
    endtask

    // Bounded wait for the next delivered byte, compared against the scoreboard.
    task automatic wait_byte(input string name);
        logic [7:0] exp;
        int t;
        exp = exp_q.pop_front();
        t = 0;
        while (got_n <= rd && t < 60) begin
            tick(1);
            t++;
        end
        checks++;
        if (got_n <= rd) begin
            errors++;
            $display("FAIL %s: no byte received, expected %02h", name, exp);
        end else begin
            if (got_mem[rd[7:0]] !== exp) begin
                errors++;
                $display("FAIL %s: got %02h expected %02h", name, got_mem[rd[7:0]], exp);
            end
            rd++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", data); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++;
        if ({frame_err, overrun, parity_err} !== 3'b000) begin
            errors++; $display("FAIL reset_errs: got %b expected 000", {frame_err, overrun, parity_err});
        end
    endtask

    task automatic test_basic();
        int vc, fe, ov, pe;
        vc = valid_cycles; fe = fe_cnt; ov = ov_cnt; pe = pe_cnt;
        ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        wait_byte("basic_data");
        tick(4);
        checks++;
        if (valid_cycles - vc != 1) begin errors++; $display("FAIL basic_valid_len: got %0d expected 1", valid_cycles - vc); end
        checks++;
        if (fe_cnt - fe != 0 || ov_cnt - ov != 0 || pe_cnt - pe != 0) begin
            errors++; $display("FAIL basic_errs: got fe=%0d ov=%0d pe=%0d expected 0", fe_cnt - fe, ov_cnt - ov, pe_cnt - pe);
        end
    endtask

    task automatic test_glitch();
        int fe, ov, pe;
        fe = fe_cnt; ov = ov_cnt; pe = pe_cnt;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        checks++;
        if (got_n != rd || valid !== 1'b0) begin errors++; $display("FAIL glitch_nobyte: got bytes=%0d valid=%b expected 0", got_n - rd, valid); end
        checks++;
        if (fe_cnt - fe != 0 || ov_cnt - ov != 0 || pe_cnt - pe != 0) begin
            errors++; $display("FAIL glitch_errs: got fe=%0d ov=%0d pe=%0d expected 0", fe_cnt - fe, ov_cnt - ov, pe_cnt - pe);
        end
        checks++;
        if (dut.state !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dut.state, IDLE); end
    endtask

    task automatic test_frame_err();
        int fe;
        fe = fe_cnt;
        send_byte(8'h3C, 1'b0);
        tick(40);
        checks++;
        if (fe_cnt - fe != 1) begin errors++; $display("FAIL frame_err_count: got %0d expected 1", fe_cnt - fe); end
        checks++;
        if (got_n != rd || valid !== 1'b0) begin errors++; $display("FAIL frame_err_novalid: got bytes=%0d valid=%b expected 0", got_n - rd, valid); end
        rx = 1'b1;
        tick(5);
        checks++;
        if (fe_cnt - fe != 1) begin errors++; $display("FAIL break_single: got %0d expected 1", fe_cnt - fe); end
        exp_q.push_back(8'h01);
        send_byte(8'h01, 1'b1);
        wait_byte("after_break_data");
    endtask

    task automatic test_back_to_back();
        int ov;
        ov = ov_cnt;
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(4);
        checks++;
        if (valid !== 1'b1 || data !== 8'h11) begin errors++; $display("FAIL overrun_hold: got valid=%b data=%02h expected 1/11", valid, data); end
        checks++;
        if (ov_cnt - ov != 1) begin errors++; $display("FAIL overrun_count: got %0d expected 1", ov_cnt - ov); end
        ready = 1'b1;
        tick(2);
        checks++;
        if (valid !== 1'b0 || data !== 8'h11) begin errors++; $display("FAIL overrun_release: got valid=%b data=%02h expected 0/11", valid, data); end
        wait_byte("overrun_data");
    endtask

    task automatic test_reset_mid();
        fork
            send_byte(8'hFF, 1'b1);
            begin
                tick(CPB * 4 + 8);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                checks++;
                if (valid !== 1'b0 || data !== 8'h00) begin
                    errors++; $display("FAIL midreset_outputs: got valid=%b data=%02h expected 0/00", valid, data);
                end
            end
        join
        tick(20);
        checks++;
        if (got_n != rd) begin errors++; $display("FAIL midreset_nobyte: got %0d bytes expected 0", got_n - rd); end
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        wait_byte("midreset_next");
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int pe;
        pe = pe_cnt;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b0, 1'b1);
        wait_byte("parity_bad_data");
        tick(2);
        checks++;
        if (pe_cnt - pe != 1) begin errors++; $display("FAIL parity_bad_pulse: got %0d expected 1", pe_cnt - pe); end
        pe = pe_cnt;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_byte("parity_good_data");
        tick(2);
        checks++;
        if (pe_cnt - pe != 0) begin errors++; $display("FAIL parity_good_pulse: got %0d expected 0", pe_cnt - pe); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
